rf_operand_seq: RTL and testbench

Operand-fetch sequencer for the single-read-port register file. It accepts a decode request naming up to two source registers and time-multiplexes the file's one combinational read port over consecutive cycles. It assembles both operands, bypassing a same-cycle write-back, and presents them to execute with a valid/ready handshake. It sits between decode and execute, driving the register file's read address and snooping its write port.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_operand_seq_if.sv | 50 +++++
 rtl/rf_bypass_mux.sv | 27 ++
 rtl/rf_operand_seq.sv | 117 +++++++++++
 tb/tb_rf_operand_seq.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rf_pkg.sv
// Shared register-file definitions: default widths and the operand
// sequencer state encoding.
package rf_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD1  = 2'd1,
        RD2  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/rf_operand_seq_if.sv
// Bus bundle between decode, the register file ports and execute, as seen by
// the operand-fetch sequencer.
//
// Handshake: a transfer happens on a posedge where valid && ready are both 1.
// The source holds valid and its payload stable until that edge; ready may
// depend combinationally on valid; valid never depends on ready.
interface rf_operand_seq_if
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) ();

    logic                  req_valid;
    logic                  req_ready;
    logic [ADDR_WIDTH-1:0] req_rs1;
    logic [ADDR_WIDTH-1:0] req_rs2;
    logic                  req_use_rs2;

    logic [ADDR_WIDTH-1:0] rf_raddr;
    logic [DATA_WIDTH-1:0] rf_rdata;

    logic                  wb_wen;
    logic [ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0] wb_wdata;

    logic                  op_valid;
    logic                  op_ready;
    logic [DATA_WIDTH-1:0] op_src1;
    logic [DATA_WIDTH-1:0] op_src2;

    // Environment side: decode, register file and execute.
    modport master (
        output req_valid, req_rs1, req_rs2, req_use_rs2,
        output rf_rdata,
        output wb_wen, wb_waddr, wb_wdata,
        output op_ready,
        input  req_ready, rf_raddr, op_valid, op_src1, op_src2
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_rs1, req_rs2, req_use_rs2,
        input  rf_rdata,
        input  wb_wen, wb_waddr, wb_wdata,
        input  op_ready,
        output req_ready, rf_raddr, op_valid, op_src1, op_src2
    );

endinterface

// File: rtl/rf_bypass_mux.sv
// Read-data select for one register index: x0 reads as zero, a write-back to
// the same index in this cycle wins over the (stale) file read data.
module rf_bypass_mux
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] idx,
    input  logic                  wb_wen,
    input  logic [ADDR_WIDTH-1:0] wb_waddr,
    input  logic [DATA_WIDTH-1:0] wb_wdata,
    input  logic [DATA_WIDTH-1:0] rf_rdata,
    output logic [DATA_WIDTH-1:0] data
);

    // Priority: hardwired zero, then same-edge write-back, then file data.
    always_comb begin
        data = rf_rdata;
        if (idx == '0) begin
            data = '0;
        end else if (wb_wen && (wb_waddr == idx)) begin
            data = wb_wdata;
        end
    end

endmodule

// File: rtl/rf_operand_seq.sv
// Operand-fetch sequencer: shares the register file's single read port over
// two cycles, keeps captured operands coherent with write-back until the
// execute handshake, then hands both operands over.
module rf_operand_seq
    import rf_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    rf_operand_seq_if.slave  bus,
    output state_t           dbg_state
);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rs1_q, rs2_q;
    logic                  use_rs2_q;
    logic [DATA_WIDTH-1:0] src1_q, src2_q;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  accept;
    logic                  hit1, hit2;

    rf_bypass_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_bypass (
        .idx      (raddr),
        .wb_wen   (bus.wb_wen),
        .wb_waddr (bus.wb_waddr),
        .wb_wdata (bus.wb_wdata),
        .rf_rdata (bus.rf_rdata),
        .data     (sel_data)
    );

    // A write to a latched nonzero source index must refresh that operand.
    assign hit1   = bus.wb_wen && (bus.wb_waddr == rs1_q) && (rs1_q != '0);
    assign hit2   = bus.wb_wen && (bus.wb_waddr == rs2_q) && (rs2_q != '0);
    assign accept = bus.req_valid && bus.req_ready;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, read address and handshake outputs.
    always_comb begin
        state_d       = state_q;
        raddr         = '0;
        bus.req_ready = 1'b0;
        bus.op_valid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_d = RD1;
            end
            RD1: begin
                raddr   = rs1_q;
                state_d = use_rs2_q ? RD2 : DONE;
            end
            RD2: begin
                raddr   = rs2_q;
                state_d = DONE;
            end
            DONE: begin
                bus.op_valid  = 1'b1;
                bus.req_ready = bus.op_ready;
                if (bus.op_ready) state_d = bus.req_valid ? RD1 : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request latch, operand capture and write-back coherence.
    always_ff @(posedge clk) begin
        if (rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            use_rs2_q <= 1'b0;
            src1_q    <= '0;
            src2_q    <= '0;
        end else begin
            if (accept) begin
                rs1_q     <= bus.req_rs1;
                rs2_q     <= bus.req_rs2;
                use_rs2_q <= bus.req_use_rs2;
            end
            case (state_q)
                RD1: begin
                    src1_q <= sel_data;
                    if (!use_rs2_q) src2_q <= '0;
                end
                RD2: begin
                    src2_q <= sel_data;
                    if (hit1) src1_q <= bus.wb_wdata;
                end
                DONE: begin
                    if (hit1) src1_q <= bus.wb_wdata;
                    // A one-operand request keeps src2 at zero.
                    if (hit2 && use_rs2_q) src2_q <= bus.wb_wdata;
                end
                default: ;
            endcase
        end
    end

    assign bus.rf_raddr = raddr;
    assign bus.op_src1  = src1_q;
    assign bus.op_src2  = src2_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_rf_operand_seq.sv
// Bench for rf_operand_seq: a behavioural register file on the read/write
// ports, scenario tasks with inline checks, and an operand scoreboard popped
// at every execute handshake.
module tb_rf_operand_seq;
    import rf_pkg::*;

    localparam int AW = RF_ADDR_WIDTH;
    localparam int DW = RF_DATA_WIDTH;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    state_t dbg_state;

    rf_operand_seq_if bus ();

    rf_operand_seq dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // Clock.
    always #5 clk = ~clk;

    logic [DW-1:0]   mem   [2**AW];
    logic [DW-1:0]   model [2**AW];
    logic [2*DW-1:0] exp_q [$];
    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Register file: combinational read, write at posedge, x0 not writable.
    assign bus.rf_rdata = mem[bus.rf_raddr];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.wb_wen && bus.wb_waddr != '0) mem[bus.wb_waddr] <= bus.wb_wdata;
    end

    // Scoreboard: compare operands at every execute handshake.
    always @(negedge clk) begin
        logic [2*DW-1:0] e;
        if (!rst && bus.op_valid && bus.op_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL handoff_unexpected: got %h_%h expected no handoff", bus.op_src1, bus.op_src2);
            end else begin
                e = exp_q.pop_front();
                if ({bus.op_src1, bus.op_src2} !== e) begin
                    n_err++;
                    $display("FAIL handoff_data: got %h_%h expected %h_%h", bus.op_src1, bus.op_src2, e[2*DW-1:DW], e[DW-1:0]);
                end
            end
        end
    end

    // Driver tasks.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.wb_wen   = 1'b1;
        bus.wb_waddr = a;
        bus.wb_wdata = d;
        if (a != '0) model[a] = d;
        step();
        bus.wb_wen = 1'b0;
    endtask

    task automatic drive_req(input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic u);
        bus.req_valid   = 1'b1;
        bus.req_rs1     = r1;
        bus.req_rs2     = r2;
        bus.req_use_rs2 = u;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", dbg_state, IDLE); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b expected 1", bus.req_ready); end
        n_vec++; if (bus.op_valid !== 1'b0) begin n_err++; $display("FAIL reset_op_valid: got %b expected 0", bus.op_valid); end
        n_vec++; if (bus.op_src1 !== '0) begin n_err++; $display("FAIL reset_src1: got %h expected 0", bus.op_src1); end
        n_vec++; if (bus.op_src2 !== '0) begin n_err++; $display("FAIL reset_src2: got %h expected 0", bus.op_src2); end
        n_vec++; if (bus.rf_raddr !== '0) begin n_err++; $display("FAIL reset_raddr: got %0d expected 0", bus.rf_raddr); end
    endtask

    task automatic test_two_operand();
        wr(5, 32'h11);
        wr(6, 32'h22);
        bus.op_ready = 1'b1;
        exp_q.push_back({32'h11, 32'h22});
        drive_req(5, 6, 1'b1);
        step();
        bus.req_valid = 1'b0;
        n_vec++; if (dbg_state !== RD1) begin n_err++; $display("FAIL two_op_rd1_state: got %0d expected %0d", dbg_state, RD1); end
        n_vec++; if (bus.rf_raddr !== 5'd5) begin n_err++; $display("FAIL two_op_raddr1: got %0d expected 5", bus.rf_raddr); end
        step();
        n_vec++; if (bus.rf_raddr !== 5'd6) begin n_err++; $display("FAIL two_op_raddr2: got %0d expected 6", bus.rf_raddr); end
        n_vec++; if (bus.op_valid !== 1'b0) begin n_err++; $display("FAIL two_op_early_valid: got %b expected 0", bus.op_valid); end
        step();
        n_vec++; if (bus.op_valid !== 1'b1) begin n_err++; $display("FAIL two_op_valid_n3: got %b expected 1", bus.op_valid); end
        n_vec++; if (bus.rf_raddr !== '0) begin n_err++; $display("FAIL two_op_done_raddr: got %0d expected 0", bus.rf_raddr); end
        step();
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL two_op_back_idle: got %0d expected %0d", dbg_state, IDLE); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL two_op_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_one_operand();
        wr(7, 32'h33);
        bus.op_ready = 1'b1;
        exp_q.push_back({32'h0, 32'h0});
        drive_req(0, 7, 1'b0);
        step();
        bus.req_valid = 1'b0;
        n_vec++; if (dbg_state !== RD1) begin n_err++; $display("FAIL one_op_rd1_state: got %0d expected %0d", dbg_state, RD1); end
        n_vec++; if (bus.rf_raddr !== '0) begin n_err++; $display("FAIL one_op_raddr: got %0d expected 0", bus.rf_raddr); end
        step();
        n_vec++; if (dbg_state !== DONE) begin n_err++; $display("FAIL one_op_no_rd2: got %0d expected %0d", dbg_state, DONE); end
        n_vec++; if (bus.op_valid !== 1'b1) begin n_err++; $display("FAIL one_op_valid_n2: got %b expected 1", bus.op_valid); end
        step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL one_op_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] old;
        bus.op_ready = 1'b1;
        wr(5, 32'h11);
        // Write-back to rs1 in the RD1 cycle must be forwarded.
        exp_q.push_back({32'hAA, 32'h0});
        drive_req(5, 6, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.wb_wen = 1'b1; bus.wb_waddr = 5; bus.wb_wdata = 32'hAA; model[5] = 32'hAA;
        n_vec++; if (bus.rf_raddr !== 5'd5) begin n_err++; $display("FAIL bypass_raddr: got %0d expected 5", bus.rf_raddr); end
        step();
        bus.wb_wen = 1'b0;
        n_vec++; if (bus.op_src1 !== 32'hAA) begin n_err++; $display("FAIL bypass_src1: got %h expected aa", bus.op_src1); end
        step();
        // A write to x0 is not a match; src1 keeps the file value.
        old = model[5];
        exp_q.push_back({old, 32'h0});
        drive_req(5, 6, 1'b0);
        step();
        bus.req_valid = 1'b0;
        bus.wb_wen = 1'b1; bus.wb_waddr = 0; bus.wb_wdata = 32'hCC;
        step();
        bus.wb_wen = 1'b0;
        n_vec++; if (bus.op_src1 !== old) begin n_err++; $display("FAIL bypass_x0_src1: got %h expected %h", bus.op_src1, old); end
        step();
    endtask

    task automatic test_stall();
        wr(5, 32'h11);
        wr(6, 32'h22);
        bus.op_ready = 1'b0;
        exp_q.push_back({32'h11, 32'hBB});
        drive_req(5, 6, 1'b1);
        step();
        bus.req_valid = 1'b0;
        step();
        step();
        bus.wb_wen = 1'b1; bus.wb_waddr = 6; bus.wb_wdata = 32'hBB; model[6] = 32'hBB;
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (bus.op_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid_%0d: got %b expected 1", i, bus.op_valid); end
            n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL stall_req_ready_%0d: got %b expected 0", i, bus.req_ready); end
            step();
            bus.wb_wen = 1'b0;
        end
        n_vec++; if (bus.op_src2 !== 32'hBB) begin n_err++; $display("FAIL stall_src2_coherent: got %h expected bb", bus.op_src2); end
        n_vec++; if (dbg_state !== DONE) begin n_err++; $display("FAIL stall_hold_done: got %0d expected %0d", dbg_state, DONE); end
        bus.op_ready = 1'b1;
        step();
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL stall_release_idle: got %0d expected %0d", dbg_state, IDLE); end
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL stall_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int t1;
        wr(3, 32'h1234);
        wr(4, 32'h5678);
        wr(8, 32'h9);
        wr(9, 32'hA);
        bus.op_ready = 1'b1;
        exp_q.push_back({32'h1234, 32'h5678});
        exp_q.push_back({32'h9, 32'hA});
        drive_req(3, 4, 1'b1);
        step();
        drive_req(8, 9, 1'b1);
        n_vec++; if (bus.req_ready !== 1'b0) begin n_err++; $display("FAIL b2b_busy_ready: got %b expected 0", bus.req_ready); end
        step();
        step();
        t1 = cyc;
        n_vec++; if (bus.op_valid !== 1'b1) begin n_err++; $display("FAIL b2b_first_valid: got %b expected 1", bus.op_valid); end
        n_vec++; if (bus.req_ready !== 1'b1) begin n_err++; $display("FAIL b2b_done_ready: got %b expected 1", bus.req_ready); end
        step();
        bus.req_valid = 1'b0;
        n_vec++; if (dbg_state !== RD1) begin n_err++; $display("FAIL b2b_second_accept: got %0d expected %0d", dbg_state, RD1); end
        step();
        step();
        n_vec++; if (bus.op_valid !== 1'b1) begin n_err++; $display("FAIL b2b_second_valid: got %b expected 1", bus.op_valid); end
        n_vec++; if (cyc - t1 !== 3) begin n_err++; $display("FAIL b2b_spacing: got %0d expected 3", cyc - t1); end
        step();
        n_vec++; if (exp_q.size() != 0) begin n_err++; $display("FAIL b2b_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_midflight();
        bus.op_ready = 1'b1;
        drive_req(3, 4, 1'b1);
        step();
        bus.req_valid = 1'b0;
        step();
        n_vec++; if (dbg_state !== RD2) begin n_err++; $display("FAIL rst_mid_in_rd2: got %0d expected %0d", dbg_state, RD2); end
        rst = 1'b1;
        step();
        n_vec++; if (dbg_state !== IDLE) begin n_err++; $display("FAIL rst_mid_state: got %0d expected %0d", dbg_state, IDLE); end
        n_vec++; if (bus.op_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_valid: got %b expected 0", bus.op_valid); end
        n_vec++; if (bus.op_src1 !== '0) begin n_err++; $display("FAIL rst_mid_src1: got %h expected 0", bus.op_src1); end
        n_vec++; if (bus.op_src2 !== '0) begin n_err++; $display("FAIL rst_mid_src2: got %h expected 0", bus.op_src2); end
        n_vec++; if (bus.rf_raddr !== '0) begin n_err++; $display("FAIL rst_mid_raddr: got %0d expected 0", bus.rf_raddr); end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (bus.op_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_no_handoff_%0d: got %b expected 0", i, bus.op_valid); end
        end
    endtask

    task automatic test_random();
        logic [AW-1:0] r1, r2;
        logic          u;
        logic [DW-1:0] e1, e2;
        bit            done;
        for (int a = 1; a < 2**AW; a++) wr(a[AW-1:0], $urandom);
        for (int n = 0; n < 10; n++) begin
            r1 = AW'($urandom_range(0, 2**AW - 1));
            r2 = AW'($urandom_range(0, 2**AW - 1));
            u  = 1'($urandom_range(0, 1));
            e1 = (r1 == '0) ? '0 : model[r1];
            e2 = (!u || r2 == '0) ? '0 : model[r2];
            exp_q.push_back({e1, e2});
            bus.op_ready = 1'($urandom_range(0, 1));
            drive_req(r1, r2, u);
            step();
            bus.req_valid = 1'b0;
            done = 1'b0;
            for (int k = 0; k < 40 && !done; k++) begin
                if (dbg_state == IDLE && exp_q.size() == 0) begin
                    done = 1'b1;
                end else begin
                    bus.op_ready = 1'($urandom_range(0, 1));
                    step();
                end
            end
            if (!done) begin
                n_vec++;
                n_err++;
                $display("FAIL random_timeout_%0d: got state %0d expected handoff within 40 cycles", n, dbg_state);
                exp_q.delete();
            end
        end
    endtask

    // Main sequence and final report.
    initial begin
        bus.req_valid   = 1'b0;
        bus.req_rs1     = '0;
        bus.req_rs2     = '0;
        bus.req_use_rs2 = 1'b0;
        bus.wb_wen      = 1'b0;
        bus.wb_waddr    = '0;
        bus.wb_wdata    = '0;
        bus.op_ready    = 1'b0;
        for (int i = 0; i < 2**AW; i++) model[i] = '0;
        test_reset();
        test_two_operand();
        test_one_operand();
        test_bypass();
        test_stall();
        test_back_to_back();
        test_reset_midflight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Watchdog.
    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
